// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin share of one 1RW SRAM between ports A and B; SRAM_ARB_INIT_EN adds a zero-fill INIT phase
module sram_1rw_arbiter #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 2048,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [BITS-1:0]       a_req_wdata,
    input  logic [BITS-1:0]       a_req_wmask,
    output logic                  a_rsp_valid,
    output logic [BITS-1:0]       a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [BITS-1:0]       b_req_wdata,
    input  logic [BITS-1:0]       b_req_wmask,
    output logic                  b_rsp_valid,
    output logic [BITS-1:0]       b_rsp_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd,
    output logic                  init_done
);
    logic                  prio_b_q, prio_b_d;
    logic                  rsp_a_q, rsp_a_d;
    logic                  rsp_b_q, rsp_b_d;
    logic                  grant_a, grant_b, hs_a, hs_b;
    logic                  init_active;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SRAM_ARB_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done   = (state_q == RUN);
    assign init_active = (state_q == INIT);
    assign init_addr   = cnt_q;
`else
    assign init_done   = 1'b1;
    assign init_active = 1'b0;
    assign init_addr   = '0;
`endif

    // prio_b_q set means A won the last grant, so B wins the next tie
    always_comb begin
        grant_a     = a_req_valid && (!b_req_valid || !prio_b_q);
        grant_b     = b_req_valid && !grant_a;
        a_req_ready = grant_a && init_done;
        b_req_ready = grant_b && init_done;
        hs_a        = a_req_valid && a_req_ready;
        hs_b        = b_req_valid && b_req_ready;
        prio_b_d    = hs_a ? 1'b1 : hs_b ? 1'b0 : prio_b_q;
        rsp_a_d     = hs_a && !a_req_we;
        rsp_b_d     = hs_b && !b_req_we;
        sram_ce     = init_active || hs_a || hs_b;
        sram_we     = init_active || (hs_a ? a_req_we : hs_b && b_req_we);
        sram_addr   = init_active ? init_addr : hs_a ? a_req_addr : hs_b ? b_req_addr : '0;
        sram_wd     = hs_a ? a_req_wdata : hs_b ? b_req_wdata : '0;
        sram_wmask  = init_active ? '1 : hs_a ? a_req_wmask : hs_b ? b_req_wmask : '0;
        a_rsp_valid = rsp_a_q;
        b_rsp_valid = rsp_b_q;
        a_rsp_rdata = rsp_a_q ? sram_rd : '0;
        b_rsp_rdata = rsp_b_q ? sram_rd : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b_q <= 1'b0;
            rsp_a_q  <= 1'b0;
            rsp_b_q  <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
            rsp_a_q  <= rsp_a_d;
            rsp_b_q  <= rsp_b_d;
        end
    end
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed and random checks of sram_1rw_arbiter against a request-level reference model
module tb_sram_1rw_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [10:0] a_req_addr = '0;
    logic [31:0] a_req_wdata = '0, a_req_wmask = '0;
    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [10:0] b_req_addr = '0;
    logic [31:0] b_req_wdata = '0, b_req_wmask = '0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        sram_ce, sram_we, init_done;
    logic [10:0] sram_addr;
    logic [31:0] sram_wd, sram_wmask, sram_rd;
    logic [31:0] mem [2048];

    sram_1rw_arbiter #(.BITS(32), .WORD_DEPTH(2048), .ADDR_WIDTH(11)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_wmask(b_req_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wd(sram_wd),
        .sram_wmask(sram_wmask), .sram_rd(sram_rd), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // behavioural 1RW macro with registered read
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
            else sram_rd <= mem[sram_addr];
        end
    end

    int          checks = 0, errors = 0;
    int          last = 0, last_win = 0, n;
    int          seq [4];
    logic        init_ok = 1'b0;
    logic        exp_a_v = 1'b0, exp_b_v = 1'b0;
    logic [31:0] exp_a_d = '0, exp_b_d = '0;
    logic [31:0] ref_mem [2048];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

    task automatic step();
        int win;
        @(negedge clk);
        win = 0;
        if (init_ok) begin
            if (a_req_valid && b_req_valid) win = (last == 1) ? 2 : 1;
            else if (a_req_valid) win = 1;
            else if (b_req_valid) win = 2;
        end
        chk("a_ready", a_req_ready, win == 1);
        chk("b_ready", b_req_ready, win == 2);
        chk("ce", sram_ce, win != 0);
        chk("we", sram_we, win == 1 ? a_req_we : win == 2 ? b_req_we : 1'b0);
        chk("addr", sram_addr, win == 1 ? a_req_addr : win == 2 ? b_req_addr : 11'd0);
        chk("wd", sram_wd, win == 1 ? a_req_wdata : win == 2 ? b_req_wdata : 32'd0);
        chk("wmask", sram_wmask, win == 1 ? a_req_wmask : win == 2 ? b_req_wmask : 32'd0);
        chk("a_rsp_valid", a_rsp_valid, exp_a_v);
        chk("a_rsp_rdata", a_rsp_rdata, exp_a_d);
        chk("b_rsp_valid", b_rsp_valid, exp_b_v);
        chk("b_rsp_rdata", b_rsp_rdata, exp_b_d);
        chk("init_done", init_done, init_ok);
        @(posedge clk);
        exp_a_v = 1'b0; exp_a_d = '0; exp_b_v = 1'b0; exp_b_d = '0;
        if (win == 1) begin
            if (a_req_we) ref_mem[a_req_addr] = merge(ref_mem[a_req_addr], a_req_wdata, a_req_wmask);
            else begin exp_a_v = 1'b1; exp_a_d = ref_mem[a_req_addr]; end
        end else if (win == 2) begin
            if (b_req_we) ref_mem[b_req_addr] = merge(ref_mem[b_req_addr], b_req_wdata, b_req_wmask);
            else begin exp_b_v = 1'b1; exp_b_d = ref_mem[b_req_addr]; end
        end
        if (win != 0) last = win;
        last_win = win;
        #1;
    endtask

    task automatic idle();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
    endtask

    task automatic a_set(input logic we, input logic [10:0] ad, input logic [31:0] d, input logic [31:0] m);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = ad; a_req_wdata = d; a_req_wmask = m;
    endtask

    task automatic b_set(input logic we, input logic [10:0] ad, input logic [31:0] d, input logic [31:0] m);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = ad; b_req_wdata = d; b_req_wmask = m;
    endtask

    task automatic wait_init();
`ifdef SRAM_ARB_INIT_EN
        n = 0;
        while (!init_done && n < 3000) begin
            chk("init_ready", {a_req_ready, b_req_ready}, 2'b00);
            if (n < 2048) chk("init_addr", sram_addr, 11'(n));
            @(posedge clk); #1;
            n++;
        end
        chk("init_cycles", n, 2048);
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
`endif
        init_ok = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        init_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last = 0; last_win = 0;
        exp_a_v = 1'b0; exp_a_d = '0; exp_b_v = 1'b0; exp_b_d = '0;
        wait_init();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        chk("rst_a_rsp", a_rsp_valid, 1'b0);
        chk("rst_b_rsp", b_rsp_valid, 1'b0);
        chk("rst_ce", sram_ce, 1'b0);
`ifdef SRAM_ARB_INIT_EN
        chk("rst_init_done", init_done, 1'b0);
        #1 rst = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        chk("init_cnt100", sram_addr, 11'd100);
        rst = 1'b1;
        #1 chk("init_restart", sram_addr, 11'd0);
`else
        chk("rst_init_done", init_done, 1'b1);
`endif
        do_reset();
`ifdef SRAM_ARB_INIT_EN
        a_set(1'b0, 11'd2047, '0, '0); step(); idle(); step();
        chk("t5_rdata", exp_a_v, 1'b1);
`endif
        // test 1
        a_set(1'b1, 11'd5, 32'h12345678, '1); step();
        a_set(1'b0, 11'd5, '0, '0); step();
        chk("t1_a_rsp", a_rsp_valid, 1'b1);
        chk("t1_rdata", a_rsp_rdata, 32'h12345678);
        chk("t1_b_rsp", b_rsp_valid, 1'b0);
        idle(); step();
        // test 3
        a_set(1'b1, 11'd5, 32'hAAAAAAAA, 32'h0000FFFF); step();
        a_set(1'b0, 11'd5, '0, '0); step();
        chk("t3_rdata", a_rsp_rdata, 32'h1234AAAA);
        // test 4
        a_set(1'b1, 11'd3, 32'h33333333, '1); step();
        a_set(1'b1, 11'd7, 32'h77777777, '1); step();
        a_set(1'b0, 11'd3, '0, '0); step();
        chk("t4_a_rsp", a_rsp_valid, 1'b1);
        chk("t4_a_data", a_rsp_rdata, 32'h33333333);
        chk("t4_b_rsp0", b_rsp_valid, 1'b0);
        idle(); b_set(1'b0, 11'd7, '0, '0); step();
        chk("t4_b_rsp", b_rsp_valid, 1'b1);
        chk("t4_b_data", b_rsp_rdata, 32'h77777777);
        chk("t4_a_rsp0", a_rsp_valid, 1'b0);
        idle(); step();
        // test 2: B goes last so contention starts with A
        b_set(1'b1, 11'd9, 32'h99, '1); step();
        a_set(1'b0, 11'd3, '0, '0); b_set(1'b0, 11'd7, '0, '0);
        for (int i = 0; i < 4; i++) begin step(); seq[i] = last_win; end
        chk("t2_g0", seq[0], 1); chk("t2_g1", seq[1], 2);
        chk("t2_g2", seq[2], 1); chk("t2_g3", seq[3], 2);
        idle(); step();
        // random traffic on a small address window, fields held while stalled
        for (int i = 0; i < 16; i++) begin a_set(1'b1, 11'(i), $urandom, '1); step(); end
        idle();
        for (int c = 0; c < 400; c++) begin
            if (!(a_req_valid && last_win != 1)) begin
                a_req_valid = 1'($urandom_range(0, 1));
                a_req_we = 1'($urandom_range(0, 1));
                a_req_addr = 11'($urandom_range(0, 15));
                a_req_wdata = $urandom; a_req_wmask = $urandom;
            end
            if (!(b_req_valid && last_win != 2)) begin
                b_req_valid = 1'($urandom_range(0, 1));
                b_req_we = 1'($urandom_range(0, 1));
                b_req_addr = 11'($urandom_range(0, 15));
                b_req_wdata = $urandom; b_req_wmask = $urandom;
            end
            step();
        end
        idle(); step();
        // test 6
        a_set(1'b0, 11'd5, '0, '0); step();
        idle();
        rst = 1'b1;
        #1 chk("t6_rsp_drop", a_rsp_valid, 1'b0);
        do_reset();
        a_set(1'b0, 11'd3, '0, '0); b_set(1'b0, 11'd7, '0, '0); step();
        chk("t6_a_first", last_win, 1);
        idle(); step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
